// File: rtl/modexp_pkg.sv
// Shared types for the modular-exponentiation sequencer.
package modexp_pkg;

  localparam int DEFAULT_SIZE = 128;

  typedef enum logic [2:0] {
    IDLE,
    REDUCE_SEND,
    REDUCE_WAIT,
    SQ_SEND,
    SQ_WAIT,
    MUL_SEND,
    MUL_WAIT,
    DONE
  } state_e;

endpackage

// File: rtl/modexp_req_port.sv
// Two-channel (dividend/divisor) issue handshake toward the modulo unit.
// accepted_o pulses in the cycle the last outstanding channel is taken.
module modexp_req_port #(
  parameter int SIZE = 128
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [SIZE-1:0] dividend_i,
  input  logic [SIZE-1:0] divisor_i,
  output logic [SIZE-1:0] dividen_tdata_o,
  output logic            dividen_tvalid_o,
  input  logic            dividen_tready_i,
  output logic [SIZE-1:0] divisor_tdata_o,
  output logic            divisor_tvalid_o,
  input  logic            divisor_tready_i,
  output logic            accepted_o
);

  logic [SIZE-1:0] dvd_q, dvs_q;
  logic            dvd_vld_q, dvs_vld_q;
  logic            dvd_vld_d, dvs_vld_d;

  assign dvd_vld_d  = dvd_vld_q & ~dividen_tready_i;
  assign dvs_vld_d  = dvs_vld_q & ~divisor_tready_i;
  assign accepted_o = (dvd_vld_q | dvs_vld_q) & ~dvd_vld_d & ~dvs_vld_d;

  assign dividen_tdata_o  = dvd_q;
  assign dividen_tvalid_o = dvd_vld_q;
  assign divisor_tdata_o  = dvs_q;
  assign divisor_tvalid_o = dvs_vld_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dvd_q     <= '0;
      dvs_q     <= '0;
      dvd_vld_q <= 1'b0;
      dvs_vld_q <= 1'b0;
    end else if (load_i) begin
      dvd_q     <= dividend_i;
      dvs_q     <= divisor_i;
      dvd_vld_q <= 1'b1;
      dvs_vld_q <= 1'b1;
    end else begin
      dvd_vld_q <= dvd_vld_d;
      dvs_vld_q <= dvs_vld_d;
    end
  end

endmodule

// File: rtl/modexp_master.sv
// Left-to-right square-and-multiply sequencer; every reduction goes to an external modulo unit.
// Optional MODEXP_SKIP_LEADING_ZEROS_EN starts at the exponent's top set bit (not constant-time).
module modexp_master
  import modexp_pkg::*;
#(
  parameter int SIZE = DEFAULT_SIZE,
  parameter int OP_W = SIZE / 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] cmd_base,
  input  logic [OP_W-1:0] cmd_exp,
  input  logic [OP_W-1:0] cmd_mod,
  input  logic            cmd_tvalid,
  output logic            cmd_tready,
  output logic [SIZE-1:0] mod_dividen_tdata,
  output logic            mod_dividen_tvalid,
  input  logic            mod_dividen_tready,
  output logic [SIZE-1:0] mod_divisor_tdata,
  output logic            mod_divisor_tvalid,
  input  logic            mod_divisor_tready,
  input  logic [SIZE-1:0] mod_result_tdata,
  input  logic            mod_result_tvalid,
  output logic            mod_result_tready,
  output logic [OP_W-1:0] output_tdata,
  output logic            output_tvalid,
  input  logic            output_tready
);

  localparam int IW = (OP_W > 1) ? $clog2(OP_W) : 1;

  state_e          state_q, state_d;
  logic [OP_W-1:0] acc_q, acc_d, b_q, b_d, exp_q, exp_d, mod_q, mod_d;
  logic [IW-1:0]   i_q, i_d;

  logic            load;
  logic            accepted;
  logic [OP_W-1:0] mul_a, mul_b, rem;
  logic [2*OP_W-1:0] prod;
  logic [SIZE-1:0] dividend, divisor;
  logic            unused_rem_hi;

  // Remainders are always below the modulus, so only the low half matters.
  assign rem           = mod_result_tdata[OP_W-1:0];
  assign unused_rem_hi = ^mod_result_tdata[SIZE-1:OP_W];
  assign prod          = {{OP_W{1'b0}}, mul_a} * {{OP_W{1'b0}}, mul_b};
  assign output_tdata  = acc_q;

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
  logic [IW-1:0] msb_idx;
  always_comb begin
    msb_idx = '0;
    for (int k = 0; k < OP_W; k++) if (exp_q[k]) msb_idx = IW'(k);
  end
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    b_d      = b_q;
    exp_d    = exp_q;
    mod_d    = mod_q;
    i_d      = i_q;
    load     = 1'b0;
    mul_a    = acc_q;
    mul_b    = acc_q;
    dividend = SIZE'(prod);
    divisor  = SIZE'(mod_q);

    cmd_tready        = rst && (state_q == IDLE);
    mod_result_tready = (state_q == REDUCE_WAIT) || (state_q == SQ_WAIT) || (state_q == MUL_WAIT);
    output_tvalid     = (state_q == DONE);

    case (state_q)
      IDLE: begin
        dividend = SIZE'(cmd_base);
        divisor  = SIZE'(cmd_mod);
        if (cmd_tvalid && cmd_tready) begin
          exp_d = cmd_exp;
          mod_d = cmd_mod;
          if (cmd_mod <= OP_W'(1)) begin
            acc_d   = '0;
            state_d = DONE;
          end else begin
            load    = 1'b1;
            state_d = REDUCE_SEND;
          end
        end
      end
      REDUCE_SEND: if (accepted) state_d = REDUCE_WAIT;
      SQ_SEND:     if (accepted) state_d = SQ_WAIT;
      MUL_SEND:    if (accepted) state_d = MUL_WAIT;
      REDUCE_WAIT: begin
        if (mod_result_tvalid) begin
          b_d   = rem;
          acc_d = OP_W'(1);
          mul_a = OP_W'(1);
          mul_b = OP_W'(1);
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
          if (exp_q == '0) begin
            state_d = DONE;
          end else begin
            i_d     = msb_idx;
            load    = 1'b1;
            state_d = SQ_SEND;
          end
`else
          i_d     = IW'(OP_W - 1);
          load    = 1'b1;
          state_d = SQ_SEND;
`endif
        end
      end
      SQ_WAIT: begin
        if (mod_result_tvalid) begin
          acc_d = rem;
          mul_a = rem;
          if (exp_q[i_q]) begin
            mul_b   = b_q;
            load    = 1'b1;
            state_d = MUL_SEND;
          end else if (i_q == '0) begin
            state_d = DONE;
          end else begin
            mul_b   = rem;
            i_d     = i_q - IW'(1);
            load    = 1'b1;
            state_d = SQ_SEND;
          end
        end
      end
      MUL_WAIT: begin
        if (mod_result_tvalid) begin
          acc_d = rem;
          mul_a = rem;
          mul_b = rem;
          if (i_q == '0) begin
            state_d = DONE;
          end else begin
            i_d     = i_q - IW'(1);
            load    = 1'b1;
            state_d = SQ_SEND;
          end
        end
      end
      DONE:    if (output_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      b_q     <= '0;
      exp_q   <= '0;
      mod_q   <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      exp_q   <= exp_d;
      mod_q   <= mod_d;
      i_q     <= i_d;
    end
  end

  modexp_req_port #(.SIZE(SIZE)) u_req (
    .clk              (clk),
    .rst              (rst),
    .load_i           (load),
    .dividend_i       (dividend),
    .divisor_i        (divisor),
    .dividen_tdata_o  (mod_dividen_tdata),
    .dividen_tvalid_o (mod_dividen_tvalid),
    .dividen_tready_i (mod_dividen_tready),
    .divisor_tdata_o  (mod_divisor_tdata),
    .divisor_tvalid_o (mod_divisor_tvalid),
    .divisor_tready_i (mod_divisor_tready),
    .accepted_o       (accepted)
  );

endmodule

// File: tb/tb_modexp_master.sv
// Scoreboard bench for modexp_master with an ideal modulo unit model (SIZE=16, OP_W=8).
module tb_modexp_master;

  localparam int SIZE = 16;
  localparam int OP_W = 8;

  logic            clk, rst;
  logic [OP_W-1:0] cmd_base, cmd_exp, cmd_mod;
  logic            cmd_tvalid, cmd_tready;
  logic [SIZE-1:0] mod_dividen_tdata, mod_divisor_tdata, mod_result_tdata;
  logic            mod_dividen_tvalid, mod_dividen_tready;
  logic            mod_divisor_tvalid, mod_divisor_tready;
  logic            mod_result_tvalid, mod_result_tready;
  logic [OP_W-1:0] output_tdata;
  logic            output_tvalid, output_tready;

  modexp_master #(.SIZE(SIZE), .OP_W(OP_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_base(cmd_base), .cmd_exp(cmd_exp), .cmd_mod(cmd_mod),
    .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready),
    .mod_dividen_tdata(mod_dividen_tdata), .mod_dividen_tvalid(mod_dividen_tvalid),
    .mod_dividen_tready(mod_dividen_tready),
    .mod_divisor_tdata(mod_divisor_tdata), .mod_divisor_tvalid(mod_divisor_tvalid),
    .mod_divisor_tready(mod_divisor_tready),
    .mod_result_tdata(mod_result_tdata), .mod_result_tvalid(mod_result_tvalid),
    .mod_result_tready(mod_result_tready),
    .output_tdata(output_tdata), .output_tvalid(output_tvalid), .output_tready(output_tready)
  );

  typedef struct { int res; int txn; } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int txn_total = 0;
  int stall_req = 0;
  bit rnd_bp    = 0;
  logic [OP_W-1:0] cur_mod = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  function automatic int ref_pow(input int b, input int e, input int m);
    int r;
    if (m <= 1) return 0;
    r = 1;
    for (int k = 0; k < e; k++) r = (r * (b % m)) % m;
    return r;
  endfunction

  function automatic int ref_txn(input int e, input int m);
    int pc, bl, sq;
    pc = 0;
    bl = 0;
    if (m <= 1) return 0;
    for (int k = 0; k < OP_W; k++) if (e[k]) begin pc++; bl = k + 1; end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
    if (e == 0) return 1;
    sq = bl;
`else
    sq = OP_W + 0 * bl;
`endif
    return 1 + sq + pc;
  endfunction

  // Ideal modulo unit: takes both operands, answers after a short latency.
  initial begin : modulo_model
    bit got_dvd, got_dvs, busy, res_taken;
    bit prev_dvd_v, prev_dvs_v, dvd_hs, dvs_hs;
    logic [SIZE-1:0] dvd_val, dvs_val, prev_dvd, prev_dvs;
    int delay, stall_left;
    {got_dvd, got_dvs, busy, res_taken, prev_dvd_v, prev_dvs_v, dvd_hs, dvs_hs} = '0;
    dvd_val = '0; dvs_val = '0; prev_dvd = '0; prev_dvs = '0;
    delay = 0; stall_left = 0;
    mod_dividen_tready = 1'b1;
    mod_divisor_tready = 1'b1;
    mod_result_tvalid  = 1'b0;
    mod_result_tdata   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        {got_dvd, got_dvs, busy, res_taken, prev_dvd_v, prev_dvs_v, dvd_hs, dvs_hs} = '0;
        stall_left = 0;
        mod_result_tvalid = 1'b0;
        continue;
      end
      if (dvd_hs) chk("dvd_valid_drops_after_accept", mod_dividen_tvalid, 0);
      else if (prev_dvd_v) begin
        chk("dvd_valid_held", mod_dividen_tvalid, 1);
        chk("dvd_data_held", mod_dividen_tdata, prev_dvd);
      end
      if (dvs_hs) chk("dvs_valid_drops_after_accept", mod_divisor_tvalid, 0);
      else if (prev_dvs_v) begin
        chk("dvs_valid_held", mod_divisor_tvalid, 1);
        chk("dvs_data_held", mod_divisor_tdata, prev_dvs);
      end
      if (mod_result_tvalid && res_taken) begin
        mod_result_tvalid = 1'b0;
        busy = 0; got_dvd = 0; got_dvs = 0;
      end
      if (busy && !mod_result_tvalid) begin
        if (delay > 0) delay--;
        else begin
          mod_result_tvalid = 1'b1;
          mod_result_tdata  = (dvs_val == 0) ? '0 : dvd_val % dvs_val;
        end
      end
      if (stall_req > 0 && mod_dividen_tvalid && !got_dvd) begin
        stall_left = stall_req;
        stall_req  = 0;
      end
      if (stall_left > 0) begin
        mod_dividen_tready = 1'b0;
        stall_left--;
      end else mod_dividen_tready = rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      mod_divisor_tready = rnd_bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      dvd_hs = mod_dividen_tvalid && mod_dividen_tready;
      dvs_hs = mod_divisor_tvalid && mod_divisor_tready;
      if (dvd_hs) begin
        chk("single_outstanding_dvd", got_dvd, 0);
        got_dvd = 1; dvd_val = mod_dividen_tdata;
      end
      if (dvs_hs) begin
        chk("single_outstanding_dvs", got_dvs, 0);
        chk("divisor_is_modulus", mod_divisor_tdata, {8'h00, cur_mod});
        got_dvs = 1; dvs_val = mod_divisor_tdata;
      end
      if (got_dvd && got_dvs && !busy) begin
        busy = 1; delay = 2; txn_total++;
      end
      res_taken  = mod_result_tvalid && mod_result_tready;
      prev_dvd_v = mod_dividen_tvalid; prev_dvd = mod_dividen_tdata;
      prev_dvs_v = mod_divisor_tvalid; prev_dvs = mod_divisor_tdata;
    end
  end

  // Output monitor: pops the scoreboard on every output handshake.
  initial begin : monitor
    bit pv, ptaken;
    logic [OP_W-1:0] pd;
    int last_total;
    exp_t e;
    pv = 0; ptaken = 0; pd = '0; last_total = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        pv = 0; ptaken = 0; last_total = txn_total;
        continue;
      end
      if (pv && !ptaken) begin
        chk("out_valid_held", output_tvalid, 1);
        chk("out_data_held", output_tdata, pd);
      end
      if (output_tvalid && output_tready) begin
        if (sb.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL unexpected_output: got data %0d, expected no output", output_tdata);
        end else begin
          e = sb.pop_front();
          chk("result", output_tdata, e.res);
          chk("txn_count", txn_total - last_total, e.txn);
        end
        last_total = txn_total;
      end
      pv = output_tvalid; pd = output_tdata; ptaken = output_tvalid && output_tready;
    end
  end

  task automatic drain(input bit rnd_out);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      if (rnd_out) output_tready = ($urandom_range(0, 1) != 0);
      n++;
    end
    output_tready = 1'b1;
    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  // Presents a command and returns in the cycle after it is accepted.
  task automatic issue(input int b, input int e, input int m, input bit expect_out);
    int n;
    exp_t x;
    @(negedge clk);
    cur_mod  = OP_W'(m);
    cmd_base = OP_W'(b); cmd_exp = OP_W'(e); cmd_mod = OP_W'(m);
    cmd_tvalid = 1'b1;
    if (expect_out) begin
      x.res = ref_pow(b, e, m);
      x.txn = ref_txn(e, m);
      sb.push_back(x);
    end
    n = 0;
    while (!cmd_tready && n < 100) begin @(negedge clk); n++; end
    chk("cmd_accepted_in_time", cmd_tready, 1);
    @(negedge clk);
    cmd_tvalid = 1'b0;
    if (m > 1) chk("issue_valids_rise", mod_dividen_tvalid && mod_divisor_tvalid, 1);
    else begin
      chk("degenerate_done", output_tvalid, 1);
      chk("degenerate_no_issue", mod_dividen_tvalid || mod_divisor_tvalid, 0);
    end
  endtask

  initial begin : stimulus
    int n, start;
    rst = 1'b0;
    cmd_tvalid = 1'b0; cmd_base = '0; cmd_exp = '0; cmd_mod = '0;
    output_tready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_tready", cmd_tready, 0);
    chk("rst_dvd_tvalid", mod_dividen_tvalid, 0);
    chk("rst_dvs_tvalid", mod_divisor_tvalid, 0);
    chk("rst_res_tready", mod_result_tready, 0);
    chk("rst_out_tvalid", output_tvalid, 0);
    chk("rst_out_tdata", output_tdata, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("idle_cmd_tready", cmd_tready, 1);

    issue(3, 5, 7, 1);   drain(0);
    issue(4, 0, 7, 1);   drain(0);
    issue(9, 3, 1, 1);   drain(0);
    issue(9, 3, 0, 1);   drain(0);
    issue(255, 255, 255, 1); drain(0);

    stall_req = 5;
    issue(5, 77, 13, 1); drain(0);

    output_tready = 1'b0;
    issue(200, 255, 251, 1);
    n = 0;
    while (!output_tvalid && n < 3000) begin @(negedge clk); n++; end
    chk("bp_output_arrives", output_tvalid, 1);
    repeat (10) @(negedge clk);
    chk("bp_valid_after_hold", output_tvalid, 1);
    output_tready = 1'b1;
    drain(0);

    // Reset while a squaring remainder is being awaited.
    start = txn_total;
    issue(7, 200, 13, 0);
    n = 0;
    while (!(mod_result_tready && (txn_total - start) >= 2) && n < 500) begin
      @(negedge clk); #1; n++;
    end
    chk("reached_sq_wait", mod_result_tready, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_dvd_tvalid", mod_dividen_tvalid, 0);
    chk("async_rst_dvs_tvalid", mod_divisor_tvalid, 0);
    chk("async_rst_res_tready", mod_result_tready, 0);
    chk("async_rst_out_tvalid", output_tvalid, 0);
    chk("async_rst_cmd_tready", cmd_tready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    issue(6, 11, 29, 1); drain(0);

    rnd_bp = 1;
    for (int k = 0; k < 40; k++) begin
      int b, e, m;
      b = $urandom_range(0, 255);
      e = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 255);
      m = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(2, 255);
      issue(b, e, m, 1);
      drain(1);
    end
    rnd_bp = 0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
